controlador_estabelecidos: RTL

//  Sequencer/arbiter for the single write port of the established-node memory (gerenciador_estabelecidos).
//  - Sweep-clears all node flags on command.
//  - Round-robin shares the write port among NUM_REQ relaxation units.
//  - Sits between the Dijkstra control path/relaxation units and the memory write port.

---
 rtl/estabelecidos_pkg.sv | 15 +
 rtl/arbitro_round_robin.sv | 45 ++++
 rtl/controlador_estabelecidos.sv | 137 +++++++++++++
 3 files changed

// File: rtl/estabelecidos_pkg.sv
// Shared types for the established-node memory write controller.
// FSM state encoding and memory depth helper.
package estabelecidos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } estado_e;

  function automatic int mem_size(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/arbitro_round_robin.sv
// Round-robin arbiter: one-hot grant plus index.
// Owns the rotating priority pointer.
module arbitro_round_robin #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;

  // Search from the pointer upward, wrapping, first valid wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && en_i &&
          req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        gnt_o[(int'(ptr_q) + k) % NUM_REQ] = 1'b1;
        idx_o = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      if (idx_o == IW'(NUM_REQ - 1)) ptr_d = '0;
      else ptr_d = idx_o + 1'b1;
    end
  end

  // Pointer moves just past the last winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/controlador_estabelecidos.sv
// Write-port sequencer for the established-node memory: sweep clear
// plus round-robin arbitration. Option: CONTROLADOR_ESTABELECIDOS_COUNT_EN.
module controlador_estabelecidos
  import estabelecidos_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 1,
  parameter int NUM_REQ    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_start_in,
  output logic                           clear_busy_out,
  output logic                           clear_done_out,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_in,
  output logic [NUM_REQ-1:0]             req_grant_out,
  output logic                           mem_write_en_out,
  output logic [ADDR_WIDTH-1:0]          mem_write_addr_out,
  output logic [DATA_WIDTH-1:0]          mem_write_data_out
`ifdef CONTROLADOR_ESTABELECIDOS_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]            settled_count_out
`endif
);

  localparam int MEM_SIZE = mem_size(ADDR_WIDTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  estado_e               state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  arb_en;
  logic                  arb_any;
  logic [IW-1:0]         arb_idx;

  // Grants only in IDLE, never while a clear starts or under reset
  assign arb_en = (state_q == IDLE) && !clear_start_in && !rst;
  assign arb_any = |req_grant_out;

  arbitro_round_robin #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req_i(req_valid_in),
    .en_i (arb_en),
    .gnt_o(req_grant_out),
    .idx_o(arb_idx)
  );

  // Next state, sweep counter and the write to issue this cycle
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = 1'b0;
    addr_d         = '0;
    data_d         = '0;
    clear_busy_out = 1'b0;
    clear_done_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start_in) begin
          state_d = CLEAR;
        end else if (arb_any) begin
          we_d   = 1'b1;
          addr_d = req_addr_in[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_d = req_data_in[arb_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      CLEAR: begin
        clear_busy_out = 1'b1;
        we_d           = 1'b1;
        addr_d         = cnt_q;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(MEM_SIZE - 1)) state_d = DONE;
      end
      DONE: begin
        clear_done_out = 1'b1;
        cnt_d          = '0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sweep counter and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_write_en_out   = we_q;
  assign mem_write_addr_out = addr_q;
  assign mem_write_data_out = data_q;

`ifdef CONTROLADOR_ESTABELECIDOS_COUNT_EN
  localparam logic [ADDR_WIDTH:0] SAT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [ADDR_WIDTH:0] set_q, set_d;

  // Count arbitrated nonzero writes; zeroed when a sweep begins
  always_comb begin
    set_d = set_q;
    if (state_q == IDLE && clear_start_in) begin
      set_d = '0;
    end else if (state_q == IDLE && we_d &&
                 data_d != '0 && set_q != SAT) begin
      set_d = set_q + 1'b1;
    end
  end

  // Settled-node counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) set_q <= '0;
    else     set_q <= set_d;
  end

  assign settled_count_out = set_q;
`endif

endmodule
